// File: rtl/weight_stream_reader.sv
// ---------------------------------------------------------------------------
// weight_stream_reader
// Reads a contiguous block of weight words from a combinational-read weight
// memory and presents them to the MAC as a valid/ready stream. A start pulse
// samples base_addr/len. The final word carries m_last. done pulses for one
// cycle once that word has been accepted, or one cycle after a start with len==0.
//
// Ports
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   start       1-cycle request to begin a block read (ignored while busy)
//   abort       cancel the current block, no done pulse (beats start/issue)
//   base_addr   first word address, sampled with start
//   len         number of words (0 .. 2**ADDR_W), sampled with start
//   mem_addr    address to the weight memory (the registered read pointer)
//   mem_q       memory read data, valid in the same cycle as mem_addr
//   m_valid, m_ready, m_data, m_last   downstream stream
//   busy        high while streaming a block
//   done        1-cycle completion pulse
// ---------------------------------------------------------------------------
module weight_stream_reader #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_q,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] rd_ptr, rd_ptr_next;
   logic [ADDR_W:0]   remaining, remaining_next;
   logic [DATA_W-1:0] data_next;
   logic              valid_next, last_next, done_next;
   logic              issue;

   assign mem_addr = rd_ptr;
   assign busy     = (state == STREAM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         remaining <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         rd_ptr    <= rd_ptr_next;
         remaining <= remaining_next;
         m_data    <= data_next;
         m_valid   <= valid_next;
         m_last    <= last_next;
         done      <= done_next;
      end
   end

   always_comb begin
      state_next     = state;
      rd_ptr_next    = rd_ptr;
      remaining_next = remaining;
      data_next      = m_data;
      valid_next     = m_valid;
      last_next      = m_last;
      done_next      = 1'b0;
      // A new word is fetched whenever words remain and the output slot is
      // empty or being emptied this cycle, giving one word per cycle.
      issue = (state == STREAM) && (remaining != '0) && (!m_valid || m_ready);

      if (abort) begin
         // rd_ptr and remaining are left as they were; the block is dropped.
         state_next = IDLE;
         valid_next = 1'b0;
         last_next  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     rd_ptr_next    = base_addr;
                     remaining_next = len;
                     state_next     = STREAM;
                  end else begin
                     done_next = 1'b1;
                  end
               end
            end
            STREAM: begin
               if (issue) begin
                  data_next      = mem_q;
                  valid_next     = 1'b1;
                  last_next      = (remaining == LEN_ONE);
                  rd_ptr_next    = rd_ptr + 1'b1;
                  remaining_next = remaining - 1'b1;
               end else if (m_valid && m_ready) begin
                  // No issue alongside acceptance of the last word, since
                  // remaining is already zero once m_last is presented.
                  valid_next = 1'b0;
                  last_next  = 1'b0;
                  if (m_last) begin
                     done_next  = 1'b1;
                     state_next = IDLE;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule
